// File: rtl/pic16f84_fetch.sv
// ---------------------------------------------------------------------------
// pic16f84_fetch
//
// Instruction-cycle phase generator and instruction prefetch for a
// PIC16F84-style core. Each instruction cycle is four clk periods, Q1..Q4.
// The program counter is latched onto the memory address at the start of Q2,
// the returned word is captured in a prefetch register at the start of Q4,
// and it is handed to the CPU as op_code at the start of the next Q1. As a
// result, the word fetched in cycle N executes in cycle N+1. A flush (branch
// or skip) turns the next handed-over instruction into a NOP.
//
// Ports
//   clk_i        system clock, all state changes on its rising edge
//   mclr_i       master clear, asynchronous, active-low
//   hold_i       stop the phase sequence at the end of Q4 (ignored in Q1-Q3)
//   pc_i         13-bit program counter from the CPU
//   flush_i      branch/skip indication, ignored while idle
//   pm_data_i    14-bit program-memory read data, valid one clk after pm_rd_o
//   q1_o..q4_o   one-hot instruction-cycle phases, all low while idle
//   pm_addr_o    13-bit program-memory read address
//   pm_rd_o      program-memory read strobe, high for the Q2 clk only
//   op_code_o    14-bit instruction presented to the CPU
//   op_valid_o   op_code_o holds a fetched, non-flushed instruction
// ---------------------------------------------------------------------------
module pic16f84_fetch (
  input  logic        clk_i,
  input  logic        mclr_i,
  input  logic        hold_i,
  input  logic [12:0] pc_i,
  input  logic        flush_i,
  input  logic [13:0] pm_data_i,
  output logic        q1_o,
  output logic        q2_o,
  output logic        q3_o,
  output logic        q4_o,
  output logic [12:0] pm_addr_o,
  output logic        pm_rd_o,
  output logic [13:0] op_code_o,
  output logic        op_valid_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_Q1,
    S_Q2,
    S_Q3,
    S_Q4
  } state_e;

  state_e      state_q, state_d;
  logic        q1_q, q2_q, q3_q, q4_q;
  logic        pm_rd_q;
  logic [12:0] pm_addr_q;
  logic [13:0] prefetch_q;
  logic        prefetch_valid_q;
  logic [13:0] op_code_q;
  logic        op_valid_q;
  logic        flush_pending_q;

  logic        flush_seen;
  logic        load_nop;

  // Once a cycle has started it always runs to Q4; hold is only looked at
  // when deciding whether to begin another cycle.
  always_comb begin
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!hold_i) state_d = S_Q1;
      S_Q1:    state_d = S_Q2;
      S_Q2:    state_d = S_Q3;
      S_Q3:    state_d = S_Q4;
      S_Q4:    state_d = hold_i ? S_IDLE : S_Q1;
      default: state_d = S_IDLE;
    endcase
  end

  // A flush seen on the transfer edge itself must still turn that transfer
  // into a NOP, so it is folded in directly rather than via flush_pending_q.
  // Before the first capture the prefetch register holds nothing to execute.
  assign flush_seen = flush_i && (state_q != S_IDLE);
  assign load_nop   = flush_pending_q || flush_seen || !prefetch_valid_q;

  // NOTE: every register here uses non-blocking assignment so all of them
  // update together from the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge mclr_i) begin
    if (!mclr_i) begin
      state_q          <= S_IDLE;
      q1_q             <= 1'b0;
      q2_q             <= 1'b0;
      q3_q             <= 1'b0;
      q4_q             <= 1'b0;
      pm_rd_q          <= 1'b0;
      pm_addr_q        <= 13'h0000;
      prefetch_q       <= 14'h0000;
      prefetch_valid_q <= 1'b0;
      op_code_q        <= 14'h0000;
      op_valid_q       <= 1'b0;
      flush_pending_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      // Phase outputs and read strobe are decoded from the next state so
      // they are registered yet line up with the state they describe.
      q1_q    <= (state_d == S_Q1);
      q2_q    <= (state_d == S_Q2);
      q3_q    <= (state_d == S_Q3);
      q4_q    <= (state_d == S_Q4);
      pm_rd_q <= (state_d == S_Q2);

      // Q2 is only entered from Q1, so this fires once per cycle.
      if (state_d == S_Q2) begin
        pm_addr_q <= pc_i;
      end

      if (state_d == S_Q4) begin
        prefetch_q       <= pm_data_i;
        prefetch_valid_q <= 1'b1;
      end

      // Transfer edge: hand the prefetched word to the CPU and consume any
      // pending flush. From IDLE, flush_seen is low so only the pending flag
      // and prefetch_valid_q matter.
      if (state_d == S_Q1) begin
        op_code_q       <= load_nop ? 14'h0000 : prefetch_q;
        op_valid_q      <= !load_nop;
        flush_pending_q <= 1'b0;
      end else if (flush_seen) begin
        flush_pending_q <= 1'b1;
      end
    end
  end

  assign q1_o       = q1_q;
  assign q2_o       = q2_q;
  assign q3_o       = q3_q;
  assign q4_o       = q4_q;
  assign pm_rd_o    = pm_rd_q;
  assign pm_addr_o  = pm_addr_q;
  assign op_code_o  = op_code_q;
  assign op_valid_o = op_valid_q;

endmodule

// File: tb/tb_pic16f84_fetch.sv
// ---------------------------------------------------------------------------
// tb_pic16f84_fetch
//
// Directed startup/fetch/flush/hold/reset/boundary scenarios followed by a
// randomized run. A phase-number reference model (0 = idle, 1..4 = Q1..Q4)
// predicts every output after each rising edge; directed points also check
// against literal values.
// ---------------------------------------------------------------------------
module tb_pic16f84_fetch;

  logic        clk = 1'b0;
  logic        mclr;
  logic        hold;
  logic [12:0] pc_in;
  logic        flush;
  logic [13:0] pm_data;
  logic        q1, q2, q3, q4;
  logic [12:0] pm_addr;
  logic        pm_rd;
  logic [13:0] op_code;
  logic        op_valid;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int          m_ph;
  logic [12:0] m_addr;
  logic [13:0] m_pf;
  logic        m_pfv;
  logic [13:0] m_op;
  logic        m_val;
  logic        m_fp;

  always #5 clk = ~clk;

  pic16f84_fetch dut (
    .clk_i      (clk),
    .mclr_i     (mclr),
    .hold_i     (hold),
    .pc_i       (pc_in),
    .flush_i    (flush),
    .pm_data_i  (pm_data),
    .q1_o       (q1),
    .q2_o       (q2),
    .q3_o       (q3),
    .q4_o       (q4),
    .pm_addr_o  (pm_addr),
    .pm_rd_o    (pm_rd),
    .op_code_o  (op_code),
    .op_valid_o (op_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph   = 0;
    m_addr = '0;
    m_pf   = '0;
    m_pfv  = 1'b0;
    m_op   = '0;
    m_val  = 1'b0;
    m_fp   = 1'b0;
  endtask

  // One rising edge of the behavioural model, using the current inputs.
  task automatic model_edge();
    int   nxt;
    logic nop;
    if (m_ph == 0 || m_ph == 4) nxt = hold ? 0 : 1;
    else                        nxt = m_ph + 1;
    if (m_ph != 0 && flush) m_fp = 1'b1;
    if (nxt == 2) m_addr = pc_in;
    if (nxt == 4) begin
      m_pf  = pm_data;
      m_pfv = 1'b1;
    end
    if (nxt == 1) begin
      nop   = m_fp || !m_pfv;
      m_op  = nop ? 14'h0000 : m_pf;
      m_val = !nop;
      m_fp  = 1'b0;
    end
    m_ph = nxt;
  endtask

  task automatic check_all(input string tag);
    logic [3:0] exp_q;
    exp_q = (m_ph == 0) ? 4'b0000 : (4'b1000 >> (m_ph - 1));
    check({tag, "_phase"},  {28'd0, q1, q2, q3, q4}, {28'd0, exp_q});
    check({tag, "_pm_rd"},  {31'd0, pm_rd},          {31'd0, (m_ph == 2)});
    check({tag, "_pm_addr"}, {19'd0, pm_addr},       {19'd0, m_addr});
    check({tag, "_op_code"}, {18'd0, op_code},       {18'd0, m_op});
    check({tag, "_op_valid"}, {31'd0, op_valid},     {31'd0, m_val});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  function automatic logic [31:0] qv();
    return {28'd0, q1, q2, q3, q4};
  endfunction

  initial begin
    mclr    = 1'b0;
    hold    = 1'b0;
    flush   = 1'b0;
    pc_in   = '0;
    pm_data = '0;
    model_reset();

    // Reset state
    #12;
    check_all("reset");

    // Startup: Q1..Q4 then Q1 again, first transfer is a NOP
    @(negedge clk);
    mclr = 1'b1;
    step("start1");
    check("start_q1", qv(), 32'b1000);
    check("start_op", {18'd0, op_code}, 32'h0);
    check("start_val", {31'd0, op_valid}, 32'h0);
    step("start2");
    check("start_q2", qv(), 32'b0100);
    step("start3");
    check("start_q3", qv(), 32'b0010);
    step("start4");
    check("start_q4", qv(), 32'b0001);
    step("start5");
    check("start_q1b", qv(), 32'b1000);

    // Fetch of 23D5 from 03D5
    pc_in = 13'h03D5;
    step("fetch_q2");
    check("fetch_addr", {19'd0, pm_addr}, 32'h03D5);
    check("fetch_rd_q2", {31'd0, pm_rd}, 32'h1);
    pm_data = 14'h23D5;
    step("fetch_q3");
    check("fetch_rd_q3", {31'd0, pm_rd}, 32'h0);
    step("fetch_q4");
    pm_data = 14'h3FFF;
    step("fetch_q1");
    check("fetch_op", {18'd0, op_code}, 32'h23D5);
    check("fetch_val", {31'd0, op_valid}, 32'h1);

    // Flush pulsed during Q3 discards prefetched 3005
    step("flush_q2");
    pm_data = 14'h3005;
    step("flush_q3");
    flush = 1'b1;
    step("flush_q4");
    flush = 1'b0;
    step("flush_q1");
    check("flush_op", {18'd0, op_code}, 32'h0);
    check("flush_val", {31'd0, op_valid}, 32'h0);
    step("flush2_q2");
    pm_data = 14'h0064;
    step("flush2_q3");
    step("flush2_q4");
    step("flush2_q1");
    check("after_flush_op", {18'd0, op_code}, 32'h0064);
    check("after_flush_val", {31'd0, op_valid}, 32'h1);

    // Hold raised in Q2: cycle completes, then idles; flush ignored while idle
    step("hold_q2");
    hold = 1'b1;
    step("hold_q3");
    step("hold_q4");
    step("hold_idle");
    check("hold_idle_q", qv(), 32'h0);
    check("hold_idle_op", {18'd0, op_code}, 32'h0064);
    flush = 1'b1;
    step("hold_idle2");
    check("hold_idle2_q", qv(), 32'h0);
    flush = 1'b0;
    hold  = 1'b0;
    step("hold_resume");
    check("hold_resume_q", qv(), 32'b1000);
    check("idle_flush_ignored", {31'd0, op_valid}, 32'h1);

    // Boundary: top address, flush held across the transfer edge
    pc_in = 13'h1FFF;
    step("bnd_q2");
    check("bnd_addr", {19'd0, pm_addr}, 32'h1FFF);
    pm_data = 14'h2ABC;
    step("bnd_q3");
    step("bnd_q4");
    flush = 1'b1;
    step("bnd_q1");
    check("bnd_nop_op", {18'd0, op_code}, 32'h0);
    check("bnd_nop_val", {31'd0, op_valid}, 32'h0);
    flush = 1'b0;
    step("bnd2_q2");
    step("bnd2_q3");
    step("bnd2_q4");
    step("bnd2_q1");
    check("bnd_pending_clear", {31'd0, op_valid}, 32'h1);
    check("bnd_op", {18'd0, op_code}, 32'h2ABC);

    // Mid-cycle reset after fetching 1234
    pm_data = 14'h1234;
    step("mr_q2");
    step("mr_q3");
    step("mr_q4");
    step("mr_q1");
    check("mr_pre_op", {18'd0, op_code}, 32'h1234);
    step("mr2_q2");
    step("mr2_q3");
    #2;
    mclr = 1'b0;
    #1;
    check("mr_q", qv(), 32'h0);
    check("mr_rd", {31'd0, pm_rd}, 32'h0);
    check("mr_op", {18'd0, op_code}, 32'h0);
    check("mr_val", {31'd0, op_valid}, 32'h0);
    model_reset();
    check_all("mr_async");
    @(negedge clk);
    mclr = 1'b1;
    step("mr_first");
    check("mr_first_op", {18'd0, op_code}, 32'h0);
    check("mr_first_val", {31'd0, op_valid}, 32'h0);

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      hold    = ($urandom_range(0, 9) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      pc_in   = 13'($urandom);
      pm_data = 14'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        #2;
        mclr = 1'b0;
        #1;
        model_reset();
        check_all("rnd_rst");
        #1;
        mclr = 1'b1;
      end
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
